// File: rtl/chaos_keystream_extractor.sv
// chaos_keystream_extractor
// Turns each float32 state triple from the affine-transform stage into three
// key bytes (taken from the fractional part of |x|), buffers the triples in a
// FIFO and streams them out byte by byte over a valid/ready handshake.
// Optional build macro KEYSTREAM_FOLD_EN: the key byte becomes the XOR of all
// four bytes of the 32-bit fraction instead of the BYTE_LSB-selected byte.
module chaos_keystream_extractor #(
    parameter int PRECISION = 32,
    parameter int DEPTH     = 8,
    parameter int AF_MARGIN = 2,
    parameter int BYTE_LSB  = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 in_valid,
    input  logic [PRECISION-1:0] x0,
    input  logic [PRECISION-1:0] x1,
    input  logic [PRECISION-1:0] x2,
    output logic [7:0]           k_data,
    output logic                 k_valid,
    input  logic                 k_ready,
    output logic                 almost_full,
    output logic                 overflow,
    output logic                 nonfinite,
    input  logic                 clr_err
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    // Fraction of |x| scaled by 2^32, reduced to one key byte.
    function automatic logic [7:0] key_byte(input logic [30:0] mag);
        logic [7:0]  e;
        logic [31:0] sig;
        logic [31:0] frac;
        int          sh;
        e    = mag[30:23];
        sig  = {8'd0, 1'b1, mag[22:0]};
        sh   = int'(e) - 118;
        frac = '0;
        // Zero/denormal and Inf/NaN contribute nothing; shifts that push every
        // significand bit outside the 32-bit window also give zero.
        if (e != 8'h00 && e != 8'hFF && sh < 32 && sh > -24) begin
            if (sh >= 0) begin
                frac = sig << sh[4:0];
            end else begin
                frac = sig >> 5'(-sh);
            end
        end
`ifdef KEYSTREAM_FOLD_EN
        return frac[31:24] ^ frac[23:16] ^ frac[15:8] ^ frac[7:0];
`else
        return 8'(frac >> BYTE_LSB);
`endif
    endfunction

    // Magnitudes only: the sign bit never affects the key.
    logic [2:0][30:0] mag;
    logic [2:0][7:0]  key_d;
    logic [2:0]       nf_hit;
    logic             unused_sign;

    assign mag         = {x2[30:0], x1[30:0], x0[30:0]};
    assign unused_sign = x0[31] ^ x1[31] ^ x2[31];

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_conv
            assign key_d[gi]  = key_byte(mag[gi]);
            assign nf_hit[gi] = (mag[gi][30:23] == 8'hFF);
        end
    endgenerate

    // Stage 1: capture the converted triple on the sampling edge.
    logic        s1_valid_q;
    logic [23:0] s1_entry_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid_q <= 1'b0;
            s1_entry_q <= '0;
        end else begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
                s1_entry_q <= key_d;
            end
        end
    end

    // Stage 2: triple FIFO plus byte serialiser.
    logic [23:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic [1:0]    byte_idx_q;
    logic          fire;
    logic          pop;
    logic          push;
    logic          drop;
    logic          overflow_q;
    logic          nonfinite_q;
    logic [23:0]   head;

    // A pop on the same edge frees the slot, so a full FIFO can still accept.
    always_comb begin
        fire    = k_valid && k_ready;
        pop     = fire && (byte_idx_q == 2'd2);
        push    = s1_valid_q && ((count_q != CW'(DEPTH)) || pop);
        drop    = s1_valid_q && !push;
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
    end

    // Storage array, no reset so it maps onto RAM.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= s1_entry_q;
        end
    end

    // Pointers, occupancy and byte index.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            byte_idx_q <= 2'd0;
        end else begin
            count_q <= count_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            if (fire) begin
                byte_idx_q <= (byte_idx_q == 2'd2) ? 2'd0 : byte_idx_q + 2'd1;
            end
        end
    end

    // Sticky error flags; a set event wins over a simultaneous clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow_q  <= 1'b0;
            nonfinite_q <= 1'b0;
        end else begin
            if (drop) begin
                overflow_q <= 1'b1;
            end else if (clr_err) begin
                overflow_q <= 1'b0;
            end
            if (in_valid && (|nf_hit)) begin
                nonfinite_q <= 1'b1;
            end else if (clr_err) begin
                nonfinite_q <= 1'b0;
            end
        end
    end

    // Head byte select; forced to zero while empty so reset clears k_data.
    always_comb begin
        head = mem_q[rd_ptr_q];
        case (byte_idx_q)
            2'd0:    k_data = head[7:0];
            2'd1:    k_data = head[15:8];
            2'd2:    k_data = head[23:16];
            default: k_data = 8'h00;
        endcase
        if (!k_valid) begin
            k_data = 8'h00;
        end
    end

    assign k_valid     = (count_q != '0);
    assign almost_full = (count_q >= CW'(DEPTH - AF_MARGIN));
    assign overflow    = overflow_q;
    assign nonfinite   = nonfinite_q;

endmodule

// File: tb/tb_chaos_keystream_extractor.sv
// Bench for chaos_keystream_extractor: two instances (key byte at bit 16 and
// bit 24) share all inputs and are checked every cycle against a queue-based
// reference model that derives key bytes from real arithmetic on |x|.
module tb_chaos_keystream_extractor;
    localparam int DEPTH     = 8;
    localparam int AF_MARGIN = 2;

    typedef struct packed {
        logic [31:0] x2;
        logic [31:0] x1;
        logic [31:0] x0;
    } trip_t;

    logic        clk;
    logic        reset_n;
    logic        in_valid;
    logic [31:0] x0, x1, x2;
    logic        k_ready;
    logic        clr_err;
    logic [7:0]  k_data16, k_data24;
    logic        k_valid16, k_valid24;
    logic        af16, af24;
    logic        ovf16, ovf24;
    logic        nf16, nf24;

    chaos_keystream_extractor #(.PRECISION(32), .DEPTH(DEPTH), .AF_MARGIN(AF_MARGIN), .BYTE_LSB(16)) u16 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .x0(x0), .x1(x1), .x2(x2),
        .k_data(k_data16), .k_valid(k_valid16), .k_ready(k_ready), .almost_full(af16),
        .overflow(ovf16), .nonfinite(nf16), .clr_err(clr_err)
    );

    chaos_keystream_extractor #(.PRECISION(32), .DEPTH(DEPTH), .AF_MARGIN(AF_MARGIN), .BYTE_LSB(24)) u24 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .x0(x0), .x1(x1), .x2(x2),
        .k_data(k_data24), .k_valid(k_valid24), .k_ready(k_ready), .almost_full(af24),
        .overflow(ovf24), .nonfinite(nf24), .clr_err(clr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    trip_t mq[$];
    trip_t pipe_t;
    bit    pipe_v;
    int    bidx;
    bit    m_ovf;
    bit    m_nf;

    // floor(frac(|x|) * 2^32) computed from the IEEE value itself
    function automatic logic [63:0] frac_scaled(input logic [31:0] x);
        int  e;
        real v;
        real fr;
        e = int'(x[30:23]);
        if (e == 255) return 64'd0;
        if (e == 0) v = real'(x[22:0]) * (2.0 ** (-149));
        else        v = (1.0 + real'(x[22:0]) / 8388608.0) * (2.0 ** (e - 127));
        fr = v - $floor(v);
        return 64'(longint'($floor(fr * 4294967296.0)));
    endfunction

    function automatic logic [7:0] mkey(input logic [31:0] x, input int lsb);
        logic [63:0] f;
        logic [7:0]  k;
        f = frac_scaled(x);
        k = 8'h00;
`ifdef KEYSTREAM_FOLD_EN
        for (int i = 0; i < 4; i++) k = k ^ 8'((f / (64'd1 << (8 * i))) % 256);
`else
        k = 8'((f / (64'd1 << lsb)) % 256);
`endif
        return k;
    endfunction

    function automatic logic [31:0] comp(input trip_t t, input int i);
        return (i == 0) ? t.x0 : ((i == 1) ? t.x1 : t.x2);
    endfunction

    function automatic logic [31:0] rnd_float();
        int         sel;
        logic [7:0] e;
        sel = $urandom_range(0, 9);
        case (sel)
            0:       e = 8'h00;
            1:       e = 8'hFF;
            2:       e = 8'($urandom_range(0, 255));
            default: e = 8'($urandom_range(100, 160));
        endcase
        return {1'($urandom), e, 23'($urandom)};
    endfunction

    function automatic trip_t rnd_trip();
        trip_t t;
        t.x0 = rnd_float();
        t.x1 = rnd_float();
        t.x2 = rnd_float();
        return t;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        pipe_v = 1'b0;
        pipe_t = '0;
        bidx   = 0;
        m_ovf  = 1'b0;
        m_nf   = 1'b0;
    endtask

    task automatic model_update(input bit iv, input trip_t t, input bit rdy, input bit clr);
        bit pop;
        bit ovf_ev;
        bit nf_ev;
        ovf_ev = 1'b0;
        pop    = (mq.size() != 0) && rdy && (bidx == 2);
        if ((mq.size() != 0) && rdy) bidx = (bidx == 2) ? 0 : bidx + 1;
        if (pop) void'(mq.pop_front());
        if (pipe_v) begin
            if (mq.size() < DEPTH) mq.push_back(pipe_t);
            else ovf_ev = 1'b1;
        end
        nf_ev = iv && ((t.x0[30:23] == 8'hFF) || (t.x1[30:23] == 8'hFF) || (t.x2[30:23] == 8'hFF));
        m_ovf = ovf_ev ? 1'b1 : (clr ? 1'b0 : m_ovf);
        m_nf  = nf_ev ? 1'b1 : (clr ? 1'b0 : m_nf);
        pipe_v = iv;
        pipe_t = t;
    endtask

    task automatic check_all();
        bit ev;
        bit eaf;
        ev  = (mq.size() != 0);
        eaf = (mq.size() >= DEPTH - AF_MARGIN);
        chk("k_valid16", k_valid16, ev);
        chk("k_valid24", k_valid24, ev);
        if (ev) begin
            chk("k_data16", k_data16, mkey(comp(mq[0], bidx), 16));
            chk("k_data24", k_data24, mkey(comp(mq[0], bidx), 24));
        end
        chk("almost_full16", af16, eaf);
        chk("almost_full24", af24, eaf);
        chk("overflow16", ovf16, m_ovf);
        chk("overflow24", ovf24, m_ovf);
        chk("nonfinite16", nf16, m_nf);
        chk("nonfinite24", nf24, m_nf);
    endtask

    // One clock: drive inputs, update model at the edge, check at the falling edge.
    task automatic step(input bit iv, input trip_t t, input bit rdy, input bit clr);
        in_valid = iv;
        x0 = t.x0;
        x1 = t.x1;
        x2 = t.x2;
        k_ready = rdy;
        clr_err = clr;
        @(posedge clk);
        model_update(iv, t, rdy, clr);
        @(negedge clk);
        check_all();
    endtask

    trip_t tz;
    trip_t t_a;
    trip_t t_s;
    logic [7:0] exp16 [3];
    logic [7:0] exp24 [3];

    initial begin
        tz  = '0;
        t_a = '{x2: 32'h3FE00000, x1: 32'h3F000000, x0: 32'h3DCCCCCD};
        t_s = '{x2: 32'h7FC00000, x1: 32'h00000001, x0: 32'hBF400000};
`ifdef KEYSTREAM_FOLD_EN
        exp16 = '{8'hB9, 8'h80, 8'hC0};
        exp24 = '{8'hB9, 8'h80, 8'hC0};
`else
        exp16 = '{8'h99, 8'h00, 8'h00};
        exp24 = '{8'h19, 8'h80, 8'hC0};
`endif
        reset_n  = 1'b0;
        in_valid = 1'b0;
        x0 = '0; x1 = '0; x2 = '0;
        k_ready  = 1'b0;
        clr_err  = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_k_valid", k_valid16, 1'b0);
        chk("rst_k_data", k_data16, 8'h00);
        chk("rst_almost_full", af16, 1'b0);
        chk("rst_overflow", ovf16, 1'b0);
        chk("rst_nonfinite", nf16, 1'b0);
        reset_n = 1'b1;

        // Single triple: latency and byte order
        step(1'b1, t_a, 1'b0, 1'b0);
        chk("lat_edge0_k_valid", k_valid16, 1'b0);
        step(1'b0, tz, 1'b0, 1'b0);
        chk("lat_edge1_k_valid", k_valid16, 1'b1);
        for (int i = 0; i < 3; i++) begin
            chk("order16", k_data16, exp16[i]);
            chk("order24", k_data24, exp24[i]);
            step(1'b0, tz, 1'b1, 1'b0);
        end
        chk("single_drained", k_valid16, 1'b0);

        // Sign, denormal and NaN handling, then clr_err
        step(1'b1, t_s, 1'b0, 1'b0);
        chk("nan_nonfinite", nf24, 1'b1);
        step(1'b0, tz, 1'b0, 1'b0);
        chk("neg_075_24", k_data24, 8'hC0);
        step(1'b0, tz, 1'b1, 1'b0);
        chk("denorm_24", k_data24, 8'h00);
        step(1'b0, tz, 1'b1, 1'b0);
        chk("nan_24", k_data24, 8'h00);
        step(1'b0, tz, 1'b1, 1'b1);
        chk("clr_nonfinite", nf24, 1'b0);

        // Backpressure: three triples held for ten cycles, then drained
        for (int i = 0; i < 3; i++) step(1'b1, rnd_trip(), 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b0, tz, 1'b0, 1'b0);
        for (int i = 0; i < 9; i++) begin
            chk("bp_stream_valid", k_valid16, 1'b1);
            step(1'b0, tz, 1'b1, 1'b0);
        end
        chk("bp_drained", k_valid16, 1'b0);

        // Fill past full: ninth triple dropped
        for (int i = 0; i < 9; i++) step(1'b1, rnd_trip(), 1'b0, 1'b0);
        step(1'b0, tz, 1'b0, 1'b0);
        chk("full_overflow", ovf16, 1'b1);
        chk("full_almost_full", af16, 1'b1);

        // Pop of full head coincides with a write
        step(1'b0, tz, 1'b0, 1'b1);
        step(1'b0, tz, 1'b1, 1'b0);
        step(1'b0, tz, 1'b1, 1'b0);
        step(1'b1, rnd_trip(), 1'b0, 1'b0);
        step(1'b0, tz, 1'b1, 1'b0);
        chk("simul_no_overflow", ovf16, 1'b0);
        chk("simul_still_full", af16, 1'b1);
        for (int i = 0; i < 3 * DEPTH + 2; i++) step(1'b0, tz, 1'b1, 1'b0);
        chk("simul_drained", k_valid16, 1'b0);

        // Twenty triples streamed through pointer wrap
        for (int i = 0; i < 60; i++) step(i % 3 == 0, rnd_trip(), 1'b1, 1'b0);

        // Random traffic
        for (int i = 0; i < 300; i++)
            step($urandom_range(0, 9) < 4, rnd_trip(), $urandom_range(0, 1) == 1, $urandom_range(0, 19) == 0);
        for (int i = 0; i < 3 * DEPTH + 4; i++) step(1'b0, tz, 1'b1, 1'b0);

        // Reset in the middle of a stream
        for (int i = 0; i < 3; i++) step(1'b1, rnd_trip(), 1'b0, 1'b0);
        in_valid = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        chk("midrst_k_valid16", k_valid16, 1'b0);
        chk("midrst_k_valid24", k_valid24, 1'b0);
        chk("midrst_k_data", k_data16, 8'h00);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        check_all();
        for (int i = 0; i < 3; i++) step(1'b0, tz, 1'b1, 1'b0);
        step(1'b1, t_a, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) step(1'b0, tz, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
